// File: rtl/neuron_mac.sv
// Sequential MAC neuron: streams LEN activations against weights fetched from a
// negedge-registered ROM and emits one saturated result. Optional macro RELU_EN clamps negatives to 0.
module neuron_mac #(
  parameter int N     = 8,
  parameter int Q     = 7,
  parameter int LEN   = 16,
  parameter int ACC_W = 2*N+8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   base_addr,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic [7:0]   rom_addr,
  input  logic [N-1:0] rom_data,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic         busy
);

  // state | meaning
  // IDLE  | waiting for start
  // PRIME | ROM fetching weight[base_addr]
  // RUN   | accepting activations, one MAC per handshake
  // OUT   | result valid for one cycle
  typedef enum logic [1:0] {IDLE, PRIME, RUN, OUT} state_t;

  localparam int CNT_W = 9;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(N-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  state_t state, state_nxt;
  logic signed [ACC_W-1:0] acc, acc_sum, shifted;
  logic signed [2*N-1:0]   act_ext, wgt_ext, prod;
  logic [CNT_W-1:0]        count;
  logic [N-1:0]            res_sat, res_final;
  logic                    hs, last;

  assign hs   = (state == RUN) && in_valid;
  assign last = hs && (count == CNT_W'(LEN - 1));

  assign act_ext = {{N{in_data[N-1]}}, in_data};
  assign wgt_ext = {{N{rom_data[N-1]}}, rom_data};
  assign prod    = act_ext * wgt_ext;
  assign acc_sum = acc + {{(ACC_W-2*N){prod[2*N-1]}}, prod};
  assign shifted = acc_sum >>> Q;

  // Result is registered on the final handshake so out_data is valid during OUT.
  always_comb begin
    if (shifted > SAT_MAX)
      res_sat = SAT_MAX[N-1:0];
    else if (shifted < SAT_MIN)
      res_sat = SAT_MIN[N-1:0];
    else
      res_sat = shifted[N-1:0];
`ifdef RELU_EN
    res_final = res_sat[N-1] ? '0 : res_sat;
`else
    res_final = res_sat;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rom_addr <= '0;
      acc      <= '0;
      count    <= '0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        rom_addr <= base_addr;
        acc      <= '0;
        count    <= '0;
      end else if (hs) begin
        acc      <= acc_sum;
        rom_addr <= rom_addr + 8'd1;
        count    <= count + CNT_W'(1);
        if (last)
          out_data <= res_final;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PRIME;
      PRIME:   state_nxt = RUN;
      RUN:     if (last) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == RUN);
    out_valid = (state == OUT);
    busy      = (state != IDLE);
  end

endmodule
